// File: rtl/multiplicador_alg2_if.sv
// Start/Done handshake bundle for the sequential shift-and-add multiplier.
interface multiplicador_alg2_if #(
    parameter int unsigned TAMANYO = 32
);
    logic                   Start;
    logic [TAMANYO-1:0]     A;
    logic [TAMANYO-1:0]     B;
    logic [2*TAMANYO-1:0]   Prod;
    logic                   Busy;
    logic                   Done;

    modport master (
        output Start, A, B,
        input  Prod, Busy, Done
    );

    modport slave (
        input  Start, A, B,
        output Prod, Busy, Done
    );
endinterface

// File: rtl/multiplicador_alg2.sv
// Sequential radix-2 shift-and-add multiplier with optional two's-complement mode.
// One add cycle plus one shift cycle per operand bit, then a sign-fix cycle.
module multiplicador_alg2 #(
    parameter int unsigned TAMANYO = 32,
    parameter bit          SIGNED  = 1'b0
) (
    input  logic                CLK,
    input  logic                RSTa,
    multiplicador_alg2_if.slave bus
);
    localparam int unsigned PW = 2 * TAMANYO;
    localparam int unsigned AW = TAMANYO + 1;
    localparam int unsigned CW = $clog2(TAMANYO);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADD   = 3'd1,
        S_SHIFT = 3'd2,
        S_FIX   = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [AW-1:0]      accu, accu_n;
    logic [TAMANYO-1:0] q, q_n;
    logic [TAMANYO-1:0] m, m_n;
    logic [CW-1:0]      cont, cont_n;
    logic               neg, neg_n;
    logic               done, done_n;
    logic               busy, busy_n;

    logic [TAMANYO-1:0] a_mag;
    logic [TAMANYO-1:0] b_mag;
    logic [AW-1:0]      sum;
    logic [AW+TAMANYO-1:0] shifted;
    logic [PW-1:0]      negated;

    // Operand magnitudes; -2^(TAMANYO-1) maps onto itself, which is correct as unsigned.
    assign a_mag = (SIGNED && bus.A[TAMANYO-1]) ? (~bus.A + TAMANYO'(1)) : bus.A;
    assign b_mag = (SIGNED && bus.B[TAMANYO-1]) ? (~bus.B + TAMANYO'(1)) : bus.B;

    // Datapath arithmetic shared by the add, shift and sign-fix steps.
    assign sum     = accu + AW'(m);
    assign shifted = {accu, q} >> 1;
    assign negated = ~{accu[TAMANYO-1:0], q} + PW'(1);

    assign bus.Prod = {accu[TAMANYO-1:0], q};
    assign bus.Busy = busy;
    assign bus.Done = done;

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state <= S_IDLE;
            accu  <= '0;
            q     <= '0;
            m     <= '0;
            cont  <= '0;
            neg   <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            accu  <= accu_n;
            q     <= q_n;
            m     <= m_n;
            cont  <= cont_n;
            neg   <= neg_n;
            done  <= done_n;
            busy  <= busy_n;
        end
    end

    // Next-state and next-datapath logic; registers hold unless a state updates them.
    always_comb begin
        state_n = state;
        accu_n  = accu;
        q_n     = q;
        m_n     = m;
        cont_n  = cont;
        neg_n   = neg;
        done_n  = 1'b0;
        busy_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.Start) begin
                    m_n     = a_mag;
                    q_n     = b_mag;
                    accu_n  = '0;
                    cont_n  = CW'(TAMANYO - 1);
                    neg_n   = SIGNED & (bus.A[TAMANYO-1] ^ bus.B[TAMANYO-1]);
                    state_n = S_ADD;
                end
            end
            S_ADD: begin
                if (q[0]) begin
                    accu_n = sum;
                end
                state_n = S_SHIFT;
            end
            S_SHIFT: begin
                accu_n = shifted[AW+TAMANYO-1:TAMANYO];
                q_n    = shifted[TAMANYO-1:0];
                cont_n = cont - CW'(1);
                if (cont == '0) begin
                    state_n = S_FIX;
                end else begin
                    state_n = S_ADD;
                end
            end
            S_FIX: begin
                if (neg) begin
                    accu_n = {1'b0, negated[PW-1:TAMANYO]};
                    q_n    = negated[TAMANYO-1:0];
                end
                done_n  = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                // Start must be seen low before a new request can be accepted.
                if (!bus.Start) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n == S_ADD) || (state_n == S_SHIFT) || (state_n == S_FIX);
    end
endmodule
